rt_receive_device: RTL and testbench

//  MKIO (GOST 26765.52 / MIL-STD-1553) remote-terminal receive channel: handles the BC->RT transfer.

---
 rtl/rt_receive_device_pkg.sv | 50 +++++
 rtl/rt_receive_device_mem.sv | 28 ++
 rtl/rt_receive_device.sv | 156 +++++++++++++++
 tb/tb_rt_receive_device.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_receive_device_pkg.sv
// Shared MKIO remote-terminal definitions: FSM states, word field positions
// and small helpers for decoding command words and building status words.
package rt_receive_device_pkg;

  localparam int WORD_W     = 16;
  localparam int PTR_W      = 5;
  localparam int MEM_DEPTH  = 32;

  // Command word fields
  localparam int CMD_ADDR_HI = 15;
  localparam int CMD_ADDR_LO = 11;
  localparam int CMD_TR      = 10;
  localparam int CMD_N_HI    = 4;
  localparam int CMD_N_LO    = 0;

  // Status word fields
  localparam int SW_ADDR_HI  = 15;
  localparam int SW_ADDR_LO  = 11;
  localparam int SW_MSG_ERR  = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DATA_WAIT,
    ST_WRITE,
    ST_CHECK,
    ST_PAUSE,
    ST_LOAD_OS,
    ST_TX_WAIT,
    ST_SEND_OS,
    ST_DONE
  } state_t;

  // Word count field of a command: 0 encodes a full 32-word message
  function automatic logic [5:0] cmd_word_count(input logic [WORD_W-1:0] cmd);
    logic [4:0] n;
    n = cmd[CMD_N_HI:CMD_N_LO];
    return (n == 5'd0) ? 6'd32 : {1'b0, n};
  endfunction

  // Response word: RT address, message-error flag, remaining flags clear
  function automatic logic [WORD_W-1:0] status_word(input logic [4:0] addr,
                                                    input logic       err);
    logic [WORD_W-1:0] sw;
    sw = '0;
    sw[SW_ADDR_HI:SW_ADDR_LO] = addr;
    sw[SW_MSG_ERR]            = err;
    return sw;
  endfunction

endpackage

// File: rtl/rt_receive_device_mem.sv
// 32x16 simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns old data.
module rt_receive_device_mem
  import rt_receive_device_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  // Write port; storage is never cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, output cleared on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/rt_receive_device.sv
// MKIO remote-terminal receive channel (BC->RT). Accepts a receive command
// for this RT, stores N data words, waits the response pause and hands the
// status word to the TX encoder. Host reads stored words via rd_addr/rd_data.
module rt_receive_device
  import rt_receive_device_pkg::*;
#(
  parameter logic [4:0] ADDRESS      = 5'd1,
  parameter logic [7:0] PAUSE_CYCLES = 8'hFF,
  parameter logic [7:0] GAP_TIMEOUT  = 8'd40,
  parameter logic [1:0] TX_STROBE    = 2'd3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] rx_data,
  input  logic              rx_cd,
  input  logic              rx_done,
  input  logic              p_error,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_cd,
  output logic              tx_ready,
  input  logic              tx_busy,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              msg_error,
  output logic [5:0]        word_count
);

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [5:0]        n_words;
  logic [7:0]        gap_cnt;
  logic [7:0]        pause_cnt;
  logic [1:0]        strb_cnt;
  logic [WORD_W-1:0] word_buf;
  logic              word_err;
  logic              cmd_ok;

  // Receive command addressed to this RT; overrides any state
  assign cmd_ok = start && (rx_data[CMD_ADDR_HI:CMD_ADDR_LO] == ADDRESS) && !rx_data[CMD_TR];

  // Hold the received data word for the WRITE cycle (rx_data is only valid with rx_done)
  always_ff @(posedge clk) begin
    if (state == ST_DATA_WAIT && rx_done) begin
      word_buf <= rx_data;
      word_err <= p_error;
    end
  end

  // Message FSM with counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tx_data    <= '0;
      tx_cd      <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      msg_error  <= 1'b0;
      word_count <= '0;
      wr_ptr     <= '0;
      n_words    <= '0;
      gap_cnt    <= '0;
      pause_cnt  <= '0;
      strb_cnt   <= '0;
    end else if (cmd_ok) begin
      state      <= ST_DATA_WAIT;
      n_words    <= cmd_word_count(rx_data);
      word_count <= '0;
      msg_error  <= 1'b0;
      wr_ptr     <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      tx_ready   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_DATA_WAIT: begin
          if (rx_done) begin
            if (rx_cd) begin
              state <= ST_WRITE;
            end else begin
              msg_error <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end else if (gap_cnt == GAP_TIMEOUT - 8'd1) begin
            msg_error <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_WRITE: begin
          msg_error  <= msg_error | word_err;
          wr_ptr     <= wr_ptr + 5'd1;
          word_count <= word_count + 6'd1;
          state      <= ST_CHECK;
        end
        ST_CHECK: begin
          if (word_count == n_words) begin
            pause_cnt <= '0;
            state     <= ST_PAUSE;
          end else begin
            gap_cnt <= '0;
            state   <= ST_DATA_WAIT;
          end
        end
        ST_PAUSE: begin
          if (rx_done) msg_error <= 1'b1;
          if (pause_cnt == PAUSE_CYCLES - 8'd1) state <= ST_LOAD_OS;
          else                                  pause_cnt <= pause_cnt + 8'd1;
        end
        ST_LOAD_OS: begin
          tx_cd   <= 1'b0;
          tx_data <= status_word(ADDRESS, msg_error);
          state   <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (!tx_busy) begin
            tx_ready <= 1'b1;
            strb_cnt <= '0;
            state    <= ST_SEND_OS;
          end
        end
        ST_SEND_OS: begin
          if (strb_cnt == TX_STROBE - 2'd1) begin
            tx_ready <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_DONE;
          end else begin
            strb_cnt <= strb_cnt + 2'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  rt_receive_device_mem u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (state == ST_WRITE),
    .waddr   (wr_ptr),
    .wdata   (word_buf),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_rt_receive_device.sv
// Bench for rt_receive_device: scenario tasks with scoreboard queues for
// expected RAM contents and expected status words.
module tb_rt_receive_device;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_cd = 1'b0;
  logic        rx_done = 1'b0;
  logic        p_error = 1'b0;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_busy = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        msg_error;
  logic [5:0]  word_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } mem_exp_t;

  mem_exp_t    mem_q[$];
  logic [15:0] status_q[$];

  int ready_cycles = 0;
  int ready_rises  = 0;
  int done_pulses  = 0;
  logic ready_prev = 1'b0;

  always #5 clk = ~clk;

  rt_receive_device dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_cd(rx_cd), .rx_done(rx_done), .p_error(p_error),
    .tx_data(tx_data), .tx_cd(tx_cd), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .msg_error(msg_error), .word_count(word_count)
  );

  // Strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (tx_ready) ready_cycles++;
    if (tx_ready && !ready_prev) ready_rises++;
    if (done) done_pulses++;
    ready_prev = tx_ready;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [15:0] w);
    start = 1'b1; rx_data = w; rx_cd = 1'b0;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic perr);
    rx_done = 1'b1; rx_data = w; rx_cd = 1'b1; p_error = perr;
    cyc(1);
    rx_done = 1'b0; p_error = 1'b0;
    cyc(2);
  endtask

  task automatic wait_tx(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic read_ram(input logic [4:0] a, output logic [15:0] d);
    rd_addr = a;
    cyc(1);
    d = rd_data;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cyc(3);
    checks++;
    if ({tx_data, tx_cd, tx_ready, busy, done, msg_error, word_count, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got tx_data=%h tx_ready=%b busy=%b done=%b msg_error=%b word_count=%0d rd_data=%h want all zero",
               tx_data, tx_ready, busy, done, msg_error, word_count, rd_data);
    end
    reset_n = 1'b1;
    cyc(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic;
    logic ok; logic [15:0] d, e16; mem_exp_t e;
    int r0, c0, d0;
    r0 = ready_rises; c0 = ready_cycles; d0 = done_pulses;
    status_q.push_back(16'h0800);
    send_cmd(16'h0803);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      send_word(16'hA001 + 16'(i), 1'b0);
      mem_q.push_back('{a: 5'(i), d: 16'hA001 + 16'(i)});
    end
    wait_tx(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_tx_ready got no strobe want strobe"); end
    e16 = status_q.pop_front();
    checks++;
    if (tx_data !== e16 || tx_cd !== 1'b0) begin errors++; $display("FAIL basic_status got %h cd=%b want %h cd=0", tx_data, tx_cd, e16); end
    wait_idle(ok);
    cyc(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_idle got busy=%b want 0", busy); end
    checks++;
    if (ready_cycles - c0 != 3) begin errors++; $display("FAIL basic_strobe_width got %0d want 3", ready_cycles - c0); end
    checks++;
    if (done_pulses - d0 != 1 || ready_rises - r0 != 1) begin errors++; $display("FAIL basic_pulses got done=%0d rises=%0d want 1 1", done_pulses - d0, ready_rises - r0); end
    checks++;
    if (word_count !== 6'd3 || msg_error !== 1'b0) begin errors++; $display("FAIL basic_count got wc=%0d err=%b want 3 0", word_count, msg_error); end
    while (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      read_ram(e.a, d);
      checks++;
      if (d !== e.d) begin errors++; $display("FAIL basic_ram[%0d] got %h want %h", e.a, d, e.d); end
    end
  endtask

  task automatic test_full_32;
    logic ok; logic [15:0] d, e16; mem_exp_t e; int r0;
    r0 = ready_rises;
    status_q.push_back(16'h0800);
    send_cmd(16'h0800);
    for (int i = 0; i < 32; i++) begin
      send_word(16'h5000 + 16'(i * 7), 1'b0);
      mem_q.push_back('{a: 5'(i), d: 16'h5000 + 16'(i * 7)});
    end
    wait_tx(ok);
    e16 = status_q.pop_front();
    checks++;
    if (!ok || tx_data !== e16) begin errors++; $display("FAIL full_status got ok=%b %h want %h", ok, tx_data, e16); end
    wait_idle(ok);
    cyc(2);
    checks++;
    if (word_count !== 6'd32 || ready_rises - r0 != 1) begin errors++; $display("FAIL full_count got wc=%0d rises=%0d want 32 1", word_count, ready_rises - r0); end
    while (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      read_ram(e.a, d);
      checks++;
      if (d !== e.d) begin errors++; $display("FAIL full_ram[%0d] got %h want %h", e.a, d, e.d); end
    end
  endtask

  task automatic test_parity;
    logic ok; logic [15:0] d, e16; mem_exp_t e;
    status_q.push_back(16'h0C00);
    send_cmd(16'h0802);
    send_word(16'hB001, 1'b0);
    mem_q.push_back('{a: 5'd0, d: 16'hB001});
    send_word(16'hB002, 1'b1);
    mem_q.push_back('{a: 5'd1, d: 16'hB002});
    wait_tx(ok);
    e16 = status_q.pop_front();
    checks++;
    if (!ok || tx_data !== e16) begin errors++; $display("FAIL parity_status got ok=%b %h want %h", ok, tx_data, e16); end
    wait_idle(ok);
    cyc(2);
    checks++;
    if (msg_error !== 1'b1 || word_count !== 6'd2) begin errors++; $display("FAIL parity_flags got err=%b wc=%0d want 1 2", msg_error, word_count); end
    while (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      read_ram(e.a, d);
      checks++;
      if (d !== e.d) begin errors++; $display("FAIL parity_ram[%0d] got %h want %h", e.a, d, e.d); end
    end
  endtask

  task automatic test_gap_timeout;
    int r0;
    r0 = ready_rises;
    send_cmd(16'h0804);
    send_word(16'hC001, 1'b0);
    send_word(16'hC002, 1'b0);
    cyc(70);
    checks++;
    if (ready_rises - r0 != 0) begin errors++; $display("FAIL gap_no_status got %0d strobes want 0", ready_rises - r0); end
    checks++;
    if (busy !== 1'b0 || msg_error !== 1'b1 || word_count !== 6'd2) begin
      errors++; $display("FAIL gap_flags got busy=%b err=%b wc=%0d want 0 1 2", busy, msg_error, word_count);
    end
  endtask

  task automatic test_filter_and_tx_busy;
    logic ok; logic [15:0] e16; int r0;
    send_cmd(16'h1003);
    cyc(2);
    checks++;
    if (busy !== 1'b0 || word_count !== 6'd2 || msg_error !== 1'b1) begin errors++; $display("FAIL addr_filter got busy=%b wc=%0d want 0 2", busy, word_count); end
    send_cmd(16'h0C03);
    cyc(2);
    checks++;
    if (busy !== 1'b0 || word_count !== 6'd2) begin errors++; $display("FAIL tr_filter got busy=%b wc=%0d want 0 2", busy, word_count); end
    r0 = ready_rises;
    tx_busy = 1'b1;
    status_q.push_back(16'h0800);
    send_cmd(16'h0801);
    send_word(16'hE001, 1'b0);
    cyc(310);
    checks++;
    if (ready_rises - r0 != 0 || busy !== 1'b1) begin errors++; $display("FAIL txbusy_hold got rises=%0d busy=%b want 0 1", ready_rises - r0, busy); end
    tx_busy = 1'b0;
    wait_tx(ok);
    e16 = status_q.pop_front();
    checks++;
    if (!ok || tx_data !== e16) begin errors++; $display("FAIL txbusy_status got ok=%b %h want %h", ok, tx_data, e16); end
    wait_idle(ok);
    cyc(2);
  endtask

  task automatic test_reset_in_pause;
    logic ok; logic [15:0] d, e16; mem_exp_t e;
    send_cmd(16'h0801);
    send_word(16'hF001, 1'b0);
    cyc(20);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_ready, busy, done, msg_error, word_count} !== '0) begin
      errors++; $display("FAIL async_reset got busy=%b wc=%0d tx_data=%h want zeros", busy, word_count, tx_data);
    end
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    status_q.push_back(16'h0800);
    send_cmd(16'h0802);
    send_word(16'h1234, 1'b0);
    mem_q.push_back('{a: 5'd0, d: 16'h1234});
    send_word(16'h5678, 1'b0);
    mem_q.push_back('{a: 5'd1, d: 16'h5678});
    wait_tx(ok);
    e16 = status_q.pop_front();
    checks++;
    if (!ok || tx_data !== e16) begin errors++; $display("FAIL post_reset_status got ok=%b %h want %h", ok, tx_data, e16); end
    wait_idle(ok);
    cyc(2);
    while (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      read_ram(e.a, d);
      checks++;
      if (d !== e.d) begin errors++; $display("FAIL post_reset_ram[%0d] got %h want %h", e.a, d, e.d); end
    end
  endtask

  task automatic test_back_to_back;
    logic ok; logic [15:0] d, e16; mem_exp_t e; int r0;
    r0 = ready_rises;
    send_cmd(16'h0803);
    send_word(16'hD0FF, 1'b0);
    status_q.push_back(16'h0800);
    send_cmd(16'h0802);
    send_word(16'hD001, 1'b0);
    mem_q.push_back('{a: 5'd0, d: 16'hD001});
    send_word(16'hD002, 1'b0);
    mem_q.push_back('{a: 5'd1, d: 16'hD002});
    wait_tx(ok);
    e16 = status_q.pop_front();
    checks++;
    if (!ok || tx_data !== e16) begin errors++; $display("FAIL restart_status got ok=%b %h want %h", ok, tx_data, e16); end
    wait_idle(ok);
    cyc(2);
    checks++;
    if (word_count !== 6'd2 || ready_rises - r0 != 1) begin errors++; $display("FAIL restart_count got wc=%0d rises=%0d want 2 1", word_count, ready_rises - r0); end
    while (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      read_ram(e.a, d);
      checks++;
      if (d !== e.d) begin errors++; $display("FAIL restart_ram[%0d] got %h want %h", e.a, d, e.d); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_32();
    test_parity();
    test_gap_timeout();
    test_filter_and_tx_busy();
    test_reset_in_pause();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
